// File: rtl/ucsbece154b_refill_arbiter_if.sv
// Bundles both caches' miss ports and the refill controller port into one interface.
// The arbiter connects through slave; the environment (caches/controller) connects through master.
interface ucsbece154b_refill_arbiter_if;
  logic        ic_req_i;
  logic [31:0] ic_addr_i;
  logic [31:0] ic_data_o;
  logic        ic_ready_o;
  logic        ic_done_o;

  logic        dc_req_i;
  logic [31:0] dc_addr_i;
  logic [31:0] dc_data_o;
  logic        dc_ready_o;
  logic        dc_done_o;

  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_i;
  logic        mem_ready_i;

  modport slave (
    input  ic_req_i, ic_addr_i, dc_req_i, dc_addr_i, mem_data_i, mem_ready_i,
    output ic_data_o, ic_ready_o, ic_done_o, dc_data_o, dc_ready_o, dc_done_o,
    output mem_req_o, mem_addr_o
  );

  modport master (
    output ic_req_i, ic_addr_i, dc_req_i, dc_addr_i, mem_data_i, mem_ready_i,
    input  ic_data_o, ic_ready_o, ic_done_o, dc_data_o, dc_ready_o, dc_done_o,
    input  mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/ucsbece154b_refill_arbiter.sv
// Shares one refill controller between the icache and dcache miss paths: round-robin
// grant on collisions, one request pulse per refill, word stream steered to the owner only.
module ucsbece154b_refill_arbiter #(
  parameter int BLOCK_SIZE = 4
) (
  input  logic                               clk,
  input  logic                               reset_i,
  ucsbece154b_refill_arbiter_if.slave        bus,
  output logic                               busy_o,
  output logic                               owner_o
);

  localparam int CW = $clog2(BLOCK_SIZE) + 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic          last_owner_q, last_owner_d;
  logic          owner_q, owner_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   ic_data_q, ic_data_d;
  logic [31:0]   dc_data_q, dc_data_d;
  logic          ic_ready_q, ic_ready_d;
  logic          dc_ready_q, dc_ready_d;
  logic          winner;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      ic_data_q    <= '0;
      dc_data_q    <= '0;
      ic_ready_q   <= 1'b0;
      dc_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      ic_data_q    <= ic_data_d;
      dc_data_q    <= dc_data_d;
      ic_ready_q   <= ic_ready_d;
      dc_ready_q   <= dc_ready_d;
    end
  end

  // On a collision the side that did not win last time goes first.
  always_comb begin
    if (bus.ic_req_i && bus.dc_req_i) winner = ~last_owner_q;
    else                              winner = bus.dc_req_i;
  end

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    ic_data_d    = ic_data_q;
    dc_data_d    = dc_data_q;
    ic_ready_d   = 1'b0;
    dc_ready_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ic_req_i || bus.dc_req_i) begin
          owner_d = winner;
          addr_d  = winner ? bus.dc_addr_i : bus.ic_addr_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        word_cnt_d = '0;
        state_d    = XFER;
      end
      XFER: begin
        if (bus.mem_ready_i) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (owner_q) begin
            dc_data_d  = bus.mem_data_i;
            dc_ready_d = 1'b1;
          end else begin
            ic_data_d  = bus.mem_data_i;
            ic_ready_d = 1'b1;
          end
          // Last word leaves the register in the DONE cycle, alongside done_o.
          if (word_cnt_q == LAST_WORD) state_d = DONE;
        end
      end
      DONE: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_req_o  = (state_q == ISSUE);
  assign bus.mem_addr_o = addr_q;
  assign bus.ic_data_o  = ic_data_q;
  assign bus.dc_data_o  = dc_data_q;
  assign bus.ic_ready_o = ic_ready_q;
  assign bus.dc_ready_o = dc_ready_q;
  assign bus.ic_done_o  = (state_q == DONE) && !owner_q;
  assign bus.dc_done_o  = (state_q == DONE) &&  owner_q;
  assign busy_o         = (state_q != IDLE);
  assign owner_o        = owner_q;

endmodule
